clock_alarm_ctrl: RTL and testbench

Top-level sequencing controller for the clock/alarm design. It owns the time-of-day and alarm-time registers and routes debounced hour/minute set buttons to whichever of the two is being edited. It advances time from a 1 Hz tick and runs the alarm ring/snooze state machine that drives the buzzer enable.

---
 rtl/clock_alarm_ctrl_if.sv | 39 +++
 rtl/clock_alarm_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_clock_alarm_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_alarm_ctrl_if.sv
// clock_alarm_ctrl_if
//   Groups the user-facing controls and the displayed time/alarm state of the
//   clock/alarm controller.
//   Controls (driven by master, read by slave):
//     sec_tick  - one-cycle pulse per second
//     set_time  - level, select SET_TIME mode (priority over set_alarm)
//     set_alarm - level, select SET_ALARM mode
//     hours_set, mins_set, snooze, stop - debounced level buttons
//     alarm_en  - level, alarm armed
//   Status (driven by slave, read by master):
//     time_hours/mins/secs, alarm_hours/mins, mode, ring, snoozed
interface clock_alarm_ctrl_if;
  logic       sec_tick;
  logic       set_time;
  logic       set_alarm;
  logic       hours_set;
  logic       mins_set;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic [4:0] time_hours;
  logic [5:0] time_mins;
  logic [5:0] time_secs;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_mins;
  logic [1:0] mode;
  logic       ring;
  logic       snoozed;

  modport master (
    output sec_tick, set_time, set_alarm, hours_set, mins_set, alarm_en, snooze, stop,
    input  time_hours, time_mins, time_secs, alarm_hours, alarm_mins, mode, ring, snoozed
  );

  modport slave (
    input  sec_tick, set_time, set_alarm, hours_set, mins_set, alarm_en, snooze, stop,
    output time_hours, time_mins, time_secs, alarm_hours, alarm_mins, mode, ring, snoozed
  );
endinterface

// File: rtl/clock_alarm_ctrl.sv
// clock_alarm_ctrl
//   Owns time-of-day and alarm-time registers, routes hour/minute set buttons
//   to whichever is being edited, advances time on sec_tick and runs the
//   alarm ring/snooze state machine.
//   Ports:
//     clk     - system clock
//     reset_n - asynchronous, active-low reset
//     bus     - clock_alarm_ctrl_if.slave (controls in, time/alarm/status out)
//   Parameters:
//     RING_SECS   - seconds of ringing before auto-off
//     SNOOZE_MINS - snooze length in minutes
module clock_alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5
) (
  input logic               clk,
  input logic               reset_n,
  clock_alarm_ctrl_if.slave bus
);

  localparam int RC_W = $clog2(RING_SECS + 1);
  localparam int SC_W = $clog2(SNOOZE_MINS * 60 + 1);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZE  = 2'b10
  } alarm_st_e;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  mode_e      mode_q, mode_d;
  alarm_st_e  st_q, st_d;
  logic [4:0] hours_q, hours_d, al_hours_q, al_hours_d;
  logic [5:0] mins_q, mins_d, secs_q, secs_d, al_mins_q, al_mins_d;
  logic [RC_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SC_W-1:0] snz_cnt_q, snz_cnt_d;
  logic hours_prev_q, mins_prev_q, snooze_prev_q, stop_prev_q;

  logic hours_edge, mins_edge, hours_ev, mins_ev, snooze_ev, stop_ev;
  logic tick_run, match, enter_set_time;

  // Rising edges; simultaneous hour+minute edges cancel each other.
  assign hours_edge = bus.hours_set & ~hours_prev_q;
  assign mins_edge  = bus.mins_set  & ~mins_prev_q;
  assign hours_ev   = hours_edge & ~mins_edge;
  assign mins_ev    = mins_edge  & ~hours_edge;
  assign snooze_ev  = bus.snooze & ~snooze_prev_q;
  assign stop_ev    = bus.stop   & ~stop_prev_q;

  always_comb begin
    mode_d         = MODE_RUN;
    hours_d        = hours_q;
    mins_d         = mins_q;
    secs_d         = secs_q;
    al_hours_d     = al_hours_q;
    al_mins_d      = al_mins_q;
    st_d           = st_q;
    ring_cnt_d     = ring_cnt_q;
    snz_cnt_d      = snz_cnt_q;
    match          = 1'b0;

    if (bus.set_time)       mode_d = MODE_SET_TIME;
    else if (bus.set_alarm) mode_d = MODE_SET_ALARM;
    enter_set_time = (mode_d == MODE_SET_TIME) && (mode_q != MODE_SET_TIME);

    // Clock halts while time is being edited.
    tick_run = bus.sec_tick && (mode_q != MODE_SET_TIME);
    if (tick_run) begin
      if (secs_q == 6'd59) begin
        secs_d = 6'd0;
        if (mins_q == 6'd59) begin
          mins_d  = 6'd0;
          hours_d = 5'(wrap_inc({1'b0, hours_q}, 6'd23));
        end else begin
          mins_d = mins_q + 6'd1;
        end
      end else begin
        secs_d = secs_q + 6'd1;
      end
    end

    // Button edges act against the mode currently registered.
    if (mode_q == MODE_SET_TIME) begin
      if (hours_ev) hours_d = 5'(wrap_inc({1'b0, hours_q}, 6'd23));
      if (mins_ev)  mins_d  = wrap_inc(mins_q, 6'd59);
    end else if (mode_q == MODE_SET_ALARM) begin
      if (hours_ev) al_hours_d = 5'(wrap_inc({1'b0, al_hours_q}, 6'd23));
      if (mins_ev)  al_mins_d  = wrap_inc(al_mins_q, 6'd59);
    end

    if (enter_set_time) secs_d = 6'd0;

    // Match compares the post-carry hh:mm with the alarm time.
    match = tick_run && bus.alarm_en && (secs_q == 6'd59) &&
            (hours_d == al_hours_q) && (mins_d == al_mins_q);

    case (st_q)
      ST_IDLE: begin
        if (match) begin
          st_d       = ST_RINGING;
          ring_cnt_d = '0;
        end
      end
      ST_RINGING: begin
        if (stop_ev) begin
          st_d = ST_IDLE;
        end else if (snooze_ev) begin
          st_d      = ST_SNOOZE;
          snz_cnt_d = SC_W'(SNOOZE_MINS * 60);
        end else if (bus.sec_tick) begin
          if (ring_cnt_q == RC_W'(RING_SECS - 1)) st_d = ST_IDLE;
          else ring_cnt_d = ring_cnt_q + RC_W'(1);
        end
      end
      ST_SNOOZE: begin
        if (stop_ev) begin
          st_d = ST_IDLE;
        end else if (bus.sec_tick) begin
          if (snz_cnt_q == SC_W'(1)) begin
            st_d       = ST_RINGING;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q - SC_W'(1);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase

    // Disarming or starting a time edit silences everything.
    if (!bus.alarm_en || enter_set_time) st_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= MODE_RUN;
      st_q          <= ST_IDLE;
      hours_q       <= '0;
      mins_q        <= '0;
      secs_q        <= '0;
      al_hours_q    <= '0;
      al_mins_q     <= '0;
      ring_cnt_q    <= '0;
      snz_cnt_q     <= '0;
      hours_prev_q  <= 1'b0;
      mins_prev_q   <= 1'b0;
      snooze_prev_q <= 1'b0;
      stop_prev_q   <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      st_q          <= st_d;
      hours_q       <= hours_d;
      mins_q        <= mins_d;
      secs_q        <= secs_d;
      al_hours_q    <= al_hours_d;
      al_mins_q     <= al_mins_d;
      ring_cnt_q    <= ring_cnt_d;
      snz_cnt_q     <= snz_cnt_d;
      hours_prev_q  <= bus.hours_set;
      mins_prev_q   <= bus.mins_set;
      snooze_prev_q <= bus.snooze;
      stop_prev_q   <= bus.stop;
    end
  end

  assign bus.time_hours  = hours_q;
  assign bus.time_mins   = mins_q;
  assign bus.time_secs   = secs_q;
  assign bus.alarm_hours = al_hours_q;
  assign bus.alarm_mins  = al_mins_q;
  assign bus.mode        = mode_q;
  assign bus.ring        = (st_q == ST_RINGING);
  assign bus.snoozed     = (st_q == ST_SNOOZE);

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// tb_clock_alarm_ctrl
//   Directed bench for clock_alarm_ctrl with RING_SECS=4, SNOOZE_MINS=1.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_clock_alarm_ctrl;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  clock_alarm_ctrl_if bus ();

  clock_alarm_ctrl #(
    .RING_SECS   (4),
    .SNOOZE_MINS (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sec_tick = 1'b1;
      @(negedge clk);
      bus.sec_tick = 1'b0;
    end
  endtask

  // which: 0 hours_set, 1 mins_set
  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) bus.hours_set = 1'b1; else bus.mins_set = 1'b1;
      @(negedge clk);
      bus.hours_set = 1'b0;
      bus.mins_set  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic bump_alarm_min(input int n);
    bus.set_alarm = 1'b1;
    @(negedge clk);
    press(1, n);
    bus.set_alarm = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n       = 1'b0;
    bus.sec_tick  = 1'b0;
    bus.set_time  = 1'b0;
    bus.set_alarm = 1'b0;
    bus.hours_set = 1'b0;
    bus.mins_set  = 1'b0;
    bus.alarm_en  = 1'b0;
    bus.snooze    = 1'b0;
    bus.stop      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hours", bus.time_hours, 0);
    chk("rst_secs", bus.time_secs, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_ring", bus.ring, 0);
    chk("rst_snoozed", bus.snoozed, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Carry chain: set 23:59, run to 23:59:58, then two ticks.
    bus.set_time = 1'b1;
    @(negedge clk);
    chk("mode_set_time", bus.mode, 1);
    press(0, 23);
    press(1, 59);
    bus.set_time = 1'b0;
    @(negedge clk);
    chk("mode_run", bus.mode, 0);
    ticks(58);
    chk("cc_secs58", bus.time_secs, 58);
    chk("cc_mins59", bus.time_mins, 59);
    chk("cc_hours23", bus.time_hours, 23);
    ticks(2);
    chk("cc_wrap_h", bus.time_hours, 0);
    chk("cc_wrap_m", bus.time_mins, 0);
    chk("cc_wrap_s", bus.time_secs, 0);

    // Set-mode behaviour.
    ticks(5);
    chk("run_secs5", bus.time_secs, 5);
    press(0, 1);
    chk("run_btn_ignored", bus.time_hours, 0);
    bus.set_time = 1'b1;
    @(negedge clk);
    chk("enter_set_secs0", bus.time_secs, 0);
    press(1, 61);
    chk("mins61", bus.time_mins, 1);
    chk("mins61_hours", bus.time_hours, 0);
    bus.hours_set = 1'b1;
    repeat (10) @(negedge clk);
    bus.hours_set = 1'b0;
    @(negedge clk);
    chk("hold_hours", bus.time_hours, 1);
    bus.hours_set = 1'b1;
    bus.mins_set  = 1'b1;
    @(negedge clk);
    bus.hours_set = 1'b0;
    bus.mins_set  = 1'b0;
    @(negedge clk);
    chk("both_hours", bus.time_hours, 1);
    chk("both_mins", bus.time_mins, 1);
    ticks(1);
    chk("set_tick_secs", bus.time_secs, 0);
    chk("set_tick_mins", bus.time_mins, 1);

    // Alarm 07:30, time 07:29:59, ring then 4-tick timeout.
    bus.set_time  = 1'b0;
    bus.set_alarm = 1'b1;
    @(negedge clk);
    chk("mode_set_alarm", bus.mode, 2);
    press(0, 7);
    press(1, 30);
    chk("alarm_hours", bus.alarm_hours, 7);
    chk("alarm_mins", bus.alarm_mins, 30);
    bus.set_alarm = 1'b0;
    bus.set_time  = 1'b1;
    @(negedge clk);
    press(0, 6);
    press(1, 28);
    bus.set_time = 1'b0;
    @(negedge clk);
    ticks(59);
    chk("t_07_29_59_m", bus.time_mins, 29);
    chk("t_07_29_59_s", bus.time_secs, 59);
    bus.alarm_en = 1'b1;
    @(negedge clk);
    ticks(1);
    chk("ring_on", bus.ring, 1);
    chk("ring_hours", bus.time_hours, 7);
    chk("ring_mins", bus.time_mins, 30);
    chk("ring_secs", bus.time_secs, 0);
    ticks(3);
    chk("ring_still", bus.ring, 1);
    ticks(1);
    chk("ring_timeout", bus.ring, 0);
    chk("timeout_snoozed", bus.snoozed, 0);

    // Snooze: alarm 07:31, time is 07:30:04.
    bump_alarm_min(1);
    ticks(55);
    chk("pre_match_ring", bus.ring, 0);
    ticks(1);
    chk("ring2_on", bus.ring, 1);
    bus.snooze = 1'b1;
    @(negedge clk);
    chk("snz_ring", bus.ring, 0);
    chk("snz_snoozed", bus.snoozed, 1);
    bus.snooze = 1'b0;
    @(negedge clk);
    ticks(59);
    chk("snz59_ring", bus.ring, 0);
    chk("snz59_snoozed", bus.snoozed, 1);
    ticks(1);
    chk("snz60_ring", bus.ring, 1);
    chk("snz60_snoozed", bus.snoozed, 0);

    // stop and snooze together: stop wins.
    bus.stop   = 1'b1;
    bus.snooze = 1'b1;
    @(negedge clk);
    chk("both_stop_ring", bus.ring, 0);
    chk("both_stop_snoozed", bus.snoozed, 0);
    bus.stop   = 1'b0;
    bus.snooze = 1'b0;
    @(negedge clk);

    // alarm_en low during SNOOZE. Time 07:32:00, alarm -> 07:33.
    bump_alarm_min(2);
    ticks(60);
    chk("ring3_on", bus.ring, 1);
    bus.snooze = 1'b1;
    @(negedge clk);
    bus.snooze = 1'b0;
    chk("ring3_snoozed", bus.snoozed, 1);
    bus.alarm_en = 1'b0;
    @(negedge clk);
    chk("disarm_snoozed", bus.snoozed, 0);
    chk("disarm_ring", bus.ring, 0);

    // Match with alarm disarmed: alarm 07:34, time 07:33:00.
    bump_alarm_min(1);
    ticks(60);
    chk("noen_mins", bus.time_mins, 34);
    chk("noen_ring", bus.ring, 0);

    // Asynchronous reset while ringing: alarm 07:35, time 07:34:00.
    bus.alarm_en = 1'b1;
    @(negedge clk);
    bump_alarm_min(1);
    ticks(60);
    chk("ring4_on", bus.ring, 1);
    bus.set_alarm = 1'b1;
    @(negedge clk);
    chk("ring4_mode", bus.mode, 2);
    chk("ring4_held", bus.ring, 1);
    bus.snooze = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ring", bus.ring, 0);
    chk("arst_mode", bus.mode, 0);
    chk("arst_hours", bus.time_hours, 0);
    chk("arst_mins", bus.time_mins, 0);
    chk("arst_alarm_mins", bus.alarm_mins, 0);
    bus.set_alarm = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_snoozed", bus.snoozed, 0);
    chk("rel_ring", bus.ring, 0);
    chk("rel_mode", bus.mode, 0);
    bus.snooze = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
